avst_adder_sched: RTL

- Packet-level scheduler that lets NREQ Avalon-ST requesters share one adder_avst-style accumulator.
- Arbitrates whole input packets round-robin onto the adder input.
- Records the owner of each forwarded packet in a tag FIFO.
- Routes each 4-byte result packet from the adder output back to the requester that owns it.

---
 rtl/avst_adder_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/avst_adder_sched.sv
// Round-robin packet scheduler sharing one Avalon-ST adder among NREQ requesters.
// Optional per-requester result counters: define AVST_SCHED_STATS_EN.
module avst_adder_sched #(
    parameter int NREQ      = 4,
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 4
) (
`ifdef AVST_SCHED_STATS_EN
    output logic [NREQ*16-1:0] pkt_count,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_end,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        add_data_in,
    output logic              add_end_in,
    output logic              add_valid_in,
    input  logic              add_ready_in,
    input  logic [7:0]        add_data_out,
    input  logic              add_end_out,
    input  logic              add_valid_out,
    output logic              add_ready_out,
    output logic [7:0]        resp_data,
    output logic              resp_end,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic              busy,
    output logic [ID_W-1:0]   grant_id
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_pick;
    logic [ID_W-1:0] w_rr_nxt;
    logic [ID_W-1:0] w_head;
    logic            w_found;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    int              w_idx;

    logic [ID_W-1:0] r_tag [TAG_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    // Descending scan so the candidate closest to rr_ptr is assigned last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = ID_W'(w_idx);
            end
        end
    end

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(TAG_DEPTH));
    assign w_head   = r_tag[r_rd_ptr];
    assign w_rr_nxt = (int'(r_grant_id) == NREQ - 1) ? '0
                    : r_grant_id + ID_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = '0;
        add_valid_in = 1'b0;
        add_data_in  = req_data[int'(r_grant_id)*8 +: 8];
        add_end_in   = req_end[r_grant_id];
        unique case (r_state)
            S_IDLE: begin
                if (!w_full && w_found) w_state_nxt = S_GRANT;
            end
            S_GRANT: begin
                add_valid_in          = req_valid[r_grant_id];
                req_ready[r_grant_id] = add_ready_in;
                if (add_valid_in && add_ready_in && add_end_in)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_push = (r_state == S_GRANT) && add_valid_in
                 && add_ready_in && add_end_in;

    // Results are held off at the adder until an owner tag exists.
    always_comb begin
        resp_valid    = '0;
        add_ready_out = 1'b0;
        if (!w_empty) begin
            resp_valid[w_head] = add_valid_out;
            add_ready_out      = resp_ready[w_head];
        end
    end

    assign w_pop     = add_valid_out && add_ready_out && add_end_out;
    assign resp_data = add_data_out;
    assign resp_end  = add_end_out;
    assign busy      = (r_state == S_GRANT);
    assign grant_id  = r_grant_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_state_nxt == S_GRANT)
                r_grant_id <= w_pick;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_rr_ptr <= w_rr_nxt;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_tag[r_wr_ptr] <= r_grant_id;
    end

`ifdef AVST_SCHED_STATS_EN
    logic [15:0] r_pkt_cnt [NREQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++)
                r_pkt_cnt[i] <= '0;
        end else if (w_pop) begin
            r_pkt_cnt[w_head] <= r_pkt_cnt[w_head] + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign pkt_count[16*g +: 16] = r_pkt_cnt[g];
    end
`endif

endmodule
